count_seq_check: RTL

Downstream consumer of the 4-bit free-running counter (count4). Samples the counter value every qualified clock and checks that it advances by exactly +1 modulo 2^WIDTH. Maintains lock status, wrap statistics and error statistics, so other logic or a bench can confirm counter health without tracing every value.

---
 rtl/count_defs.sv | 22 ++
 rtl/stat_counter.sv | 61 ++++++
 rtl/count_seq_check.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/count_defs.sv
`default_nettype none
// ============================================================================
// Module      : count_defs (package)
// Description : Shared definitions for the count4 counter and its downstream
//               sequence checker: default count width and the checker FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package count_defs;

    // Default counter width, shared with count4.
    localparam int DEF_WIDTH = 4;

    // Checker FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

endpackage : count_defs
`default_nettype wire

// File: rtl/stat_counter.sv
`default_nettype none
// ============================================================================
// Module      : stat_counter
// Description : Statistics counter with synchronous clear. With SATURATE=0 it
//               wraps modulo 2^W; with SATURATE=1 it holds at all-ones.
//               clr has priority over inc.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset
//               clr   - synchronous clear (wins over inc)
//               inc   - count enable for one event
//               value - current count
// Revision    : 1.0 - initial release
// ============================================================================
module stat_counter
    import count_defs::*;
#(
    parameter int W        = 8,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         w_at_limit;

    // A saturating counter refuses to step past all-ones; a wrapping one
    // never has a limit.
    generate
        if (SATURATE != 0) begin : g_sat
            assign w_at_limit = &value_q;
        end else begin : g_wrap
            assign w_at_limit = 1'b0;
        end
    endgenerate

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !w_at_limit) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : stat_counter
`default_nettype wire

// File: rtl/count_seq_check.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_check
// Description : Downstream checker for a free-running modulo-2^WIDTH counter.
//               Each qualified sample is classified against the previous one
//               as good (+1, including max->0 wrap), restart (0 after a
//               non-max value) or bad. An IDLE/SYNC/LOCK FSM tracks lock,
//               and wrap / error statistics are kept while locked.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-low reset
//               cnt_in     - sampled counter value
//               cnt_valid  - sample qualifier
//               clr        - synchronous clear of wrap_cnt/err_cnt/err_sticky
//               locked     - FSM is in LOCK
//               wrap_pulse - one-cycle pulse per wrap seen while locked
//               wrap_cnt   - wraps seen while locked (modulo 2^WRAP_W)
//               err_cnt    - bad steps seen while locked (saturates at 255)
//               err_sticky - set by first bad step in LOCK
//               last_cnt   - most recent sampled cnt_in
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_check
    import count_defs::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WRAP_W    = 8,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_valid,
    input  logic              clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [7:0]        err_cnt,
    output logic              err_sticky,
    output logic [WIDTH-1:0]  last_cnt
);

    localparam logic [WIDTH-1:0] c_cnt_max   = '1;
    localparam logic [2:0]       c_sync_len  = 3'(SYNC_LEN);
    localparam logic [2:0]       c_err_limit = 3'(ERR_LIMIT);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] prev_q,       prev_d;
    logic [2:0]       good_run_q,   good_run_d;
    logic [2:0]       bad_run_q,    bad_run_d;
    logic             locked_q,     locked_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             err_sticky_q, err_sticky_d;

    logic             w_step_good;
    logic             w_step_restart;
    logic             w_step_wrap;
    logic             w_wrap_inc;
    logic             w_err_inc;

    // Step classification. A 0 after max is a good wrap, so "restart" only
    // covers a 0 that did not follow max.
    always_comb begin
        w_step_good    = (cnt_in == prev_q + 1'b1);
        w_step_restart = !w_step_good && (cnt_in == '0);
        w_step_wrap    = w_step_good && (prev_q == c_cnt_max);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        wrap_pulse_d = 1'b0;
        w_wrap_inc   = 1'b0;
        w_err_inc    = 1'b0;

        if (cnt_valid) begin
            // The reference always follows the input, so after a bad value
            // the checker judges the next sample against that bad value.
            prev_d = cnt_in;
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SYNC;
                    good_run_d = '0;
                end
                ST_SYNC: begin
                    if (w_step_good) begin
                        good_run_d = good_run_q + 1'b1;
                        if (good_run_d == c_sync_len) begin
                            state_d   = ST_LOCK;
                            bad_run_d = '0;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (w_step_good) begin
                        bad_run_d = '0;
                        if (w_step_wrap) begin
                            wrap_pulse_d = 1'b1;
                            w_wrap_inc   = 1'b1;
                        end
                    end else if (w_step_restart) begin
                        state_d    = ST_SYNC;
                        good_run_d = '0;
                    end else begin
                        w_err_inc = 1'b1;
                        bad_run_d = bad_run_q + 1'b1;
                        if (bad_run_d == c_err_limit) begin
                            state_d    = ST_SYNC;
                            good_run_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);

        // clr beats a simultaneous error event.
        if (clr) begin
            err_sticky_d = 1'b0;
        end else if (w_err_inc) begin
            err_sticky_d = 1'b1;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    stat_counter #(
        .W        (WRAP_W),
        .SATURATE (0)
    ) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (w_wrap_inc),
        .value (wrap_cnt)
    );

    stat_counter #(
        .W        (8),
        .SATURATE (1)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (w_err_inc),
        .value (err_cnt)
    );

    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign err_sticky = err_sticky_q;
    assign last_cnt   = prev_q;

endmodule : count_seq_check
`default_nettype wire
